// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised single-clock FIFO.
// Holds default geometry, the occupancy-width helper and the error codes
// consumed by the downstream error aggregator.
// Optional feature macro: FIFO_STATS_EN (error-statistics counters).
package fifo_pkg;

  localparam int DATA_W_DEF = 12;
  localparam int ADDR_W_DEF = 3;
  localparam int STAT_W_DEF = 8;

  // Error codes reported to the downstream error aggregator
  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd1;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd2;

  // Occupancy needs one bit more than the pointers to represent 0..DEPTH
  function automatic int cnt_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/fifo_param_if.sv
// Handshake / status bundle between a FIFO client (master) and fifo_param (slave).
// Signals: wr_en, wr_data, rd_en, th_almost_full, th_almost_empty, err_clr (client -> FIFO);
//          rd_data, rd_valid, count, empty, full, almost_full, almost_empty, pause,
//          overflow, underflow, err_sticky (FIFO -> client).
// Optional feature macro: FIFO_STATS_EN adds ovf_cnt / udf_cnt and parameter STAT_W.
interface fifo_param_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
`ifdef FIFO_STATS_EN
  , parameter int STAT_W = STAT_W_DEF
`endif
);
  localparam int CW = cnt_w(ADDR_W);

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [CW-1:0]     th_almost_full;
  logic [CW-1:0]     th_almost_empty;
  logic              err_clr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [CW-1:0]     count;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic              almost_empty;
  logic              pause;
  logic              overflow;
  logic              underflow;
  logic              err_sticky;
`ifdef FIFO_STATS_EN
  logic [STAT_W-1:0] ovf_cnt;
  logic [STAT_W-1:0] udf_cnt;
`endif

  modport master (
    output wr_en, wr_data, rd_en, th_almost_full, th_almost_empty, err_clr,
    input  rd_data, rd_valid, count, empty, full, almost_full, almost_empty,
           pause, overflow, underflow, err_sticky
`ifdef FIFO_STATS_EN
    , input ovf_cnt, udf_cnt
`endif
  );

  modport slave (
    input  wr_en, wr_data, rd_en, th_almost_full, th_almost_empty, err_clr,
    output rd_data, rd_valid, count, empty, full, almost_full, almost_empty,
           pause, overflow, underflow, err_sticky
`ifdef FIFO_STATS_EN
    , output ovf_cnt, udf_cnt
`endif
  );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port storage array for fifo_param with a registered read port.
// Ports: clk, reset (sync, active-high, clears only the read register),
//        i_wr_en/i_wr_addr/i_wr_data write port, i_rd_en/i_rd_addr read port,
//        o_rd_data registered read data (holds when i_rd_en is low).
module fifo_mem #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // Array is deliberately not reset
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Read sees the pre-write contents when both ports hit the same slot (full + rd/wr)
  always_ff @(posedge clk) begin
    if (reset)        r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous single-clock FIFO with true full, occupancy count,
// almost-full/almost-empty thresholds, upstream pause, error pulses and sticky error.
// Ports: clk, reset (sync, active-high), bus (fifo_param_if.slave) carrying all
//        handshake, threshold, data and status signals.
// Optional feature macro: FIFO_STATS_EN adds saturating ovf_cnt/udf_cnt counters.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
`ifdef FIFO_STATS_EN
  , parameter int STAT_W = STAT_W_DEF
`endif
) (
  input logic        clk,
  input logic        reset,
  fifo_param_if.slave bus
);
  localparam int            CW      = cnt_w(ADDR_W);
  localparam int            DEPTH   = 1 << ADDR_W;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_rd_valid;
  logic              r_overflow;
  logic              r_underflow;
  logic              r_err_sticky;

  logic              w_full;
  logic              w_empty;
  logic              w_almost_full;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_ovf_next;
  logic              w_udf_next;
  logic [DATA_W-1:0] w_rd_data;

  assign w_full        = (r_count == C_DEPTH);
  assign w_empty       = (r_count == '0);
  assign w_almost_full = (r_count >= bus.th_almost_full);

  // At full a simultaneous read frees the slot, so the write is still accepted
  assign w_wr_acc   = ~reset & bus.wr_en & (~w_full | bus.rd_en);
  assign w_rd_acc   = ~reset & bus.rd_en & ~w_empty;
  assign w_ovf_next = bus.wr_en & w_full & ~bus.rd_en;
  assign w_udf_next = bus.rd_en & w_empty;

  fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (bus.wr_data),
    .i_rd_en   (w_rd_acc),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_rd_valid   <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_rd_valid  <= w_rd_acc;
      r_overflow  <= w_ovf_next;
      r_underflow <= w_udf_next;
      // A new error outranks a clear in the same cycle
      if (w_ovf_next | w_udf_next) r_err_sticky <= 1'b1;
      else if (bus.err_clr)        r_err_sticky <= 1'b0;
    end
  end

`ifdef FIFO_STATS_EN
  localparam logic [STAT_W-1:0] C_SAT = '1;

  logic [STAT_W-1:0] r_ovf_cnt;
  logic [STAT_W-1:0] r_udf_cnt;

  // An event in the clear cycle counts (or holds at saturation) instead of clearing
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf_cnt <= '0;
      r_udf_cnt <= '0;
    end else begin
      if (w_ovf_next) begin
        if (r_ovf_cnt != C_SAT) r_ovf_cnt <= r_ovf_cnt + STAT_W'(1);
      end else if (bus.err_clr) begin
        r_ovf_cnt <= '0;
      end
      if (w_udf_next) begin
        if (r_udf_cnt != C_SAT) r_udf_cnt <= r_udf_cnt + STAT_W'(1);
      end else if (bus.err_clr) begin
        r_udf_cnt <= '0;
      end
    end
  end

  assign bus.ovf_cnt = r_ovf_cnt;
  assign bus.udf_cnt = r_udf_cnt;
`endif

  assign bus.rd_data      = w_rd_data;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.count        = r_count;
  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  assign bus.almost_full  = w_almost_full;
  assign bus.almost_empty = (r_count <= bus.th_almost_empty);
  assign bus.pause        = w_almost_full | w_full;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
  assign bus.err_sticky   = r_err_sticky;

endmodule
